dmem_wait_responder: RTL and testbench



---
 rtl/dmem_wait_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_wait_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// Word-addressed data memory responder with LATENCY wait states that holds the pipeline via mem_stall.
// Optional misaligned-access trap (misalign_trap port) is built in when DMEM_MISALIGN_TRAP_EN is defined.
//
// state | meaning
// IDLE  | no access in flight; zero-latency and trapped accesses complete here
// BUSY  | access latched, counting wait cycles until cnt reaches LATENCY
module dmem_wait_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        mem_stall
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_store_q, op_store_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [31:0]   mem_q [DEPTH];

    logic          req;
    logic          misaligned;
    logic [AW-1:0] idx_in;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;
    logic [31:0]   rdata_c;
    logic          resp_c;
    logic          stall_c;
    logic          trap_c;

    assign req    = MemRead | MemWrite;
    assign idx_in = addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = (addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Upper address bits alias; low bits only matter when the trap is built in.
    logic unused_bits;
    assign unused_bits = ^{addr[31:AW+2], addr[1:0], trap_c};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_store_d = op_store_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        mem_we     = 1'b0;
        mem_widx   = idx_q;
        mem_wdata  = wdata_q;
        rdata_c    = 32'h0;
        resp_c     = 1'b0;
        stall_c    = 1'b0;
        trap_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        resp_c = 1'b1;
                        trap_c = 1'b1;
                    end else if (LAT == 4'd0) begin
                        resp_c = 1'b1;
                        if (MemWrite) begin
                            mem_we    = 1'b1;
                            mem_widx  = idx_in;
                            mem_wdata = wdata;
                        end else begin
                            rdata_c = mem_q[idx_in];
                        end
                    end else begin
                        // A store wins when both request lines are high.
                        stall_c    = 1'b1;
                        state_d    = S_BUSY;
                        cnt_d      = 4'd1;
                        op_store_d = MemWrite;
                        idx_d      = idx_in;
                        wdata_d    = wdata;
                    end
                end
            end
            default: begin
                if (cnt_q != LAT) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                end else begin
                    resp_c  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    if (op_store_q) begin
                        mem_we    = 1'b1;
                        mem_widx  = idx_q;
                        mem_wdata = wdata_q;
                    end else begin
                        rdata_c = mem_q[idx_q];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            op_store_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_store_q <= op_store_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
        end
    end

    // Array is not reset; a store pending when reset hits is dropped.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    // Outputs are forced low while reset is asserted, even with a request on the inputs.
    assign rdata      = reset ? 32'h0 : rdata_c;
    assign resp_valid = resp_c & ~reset;
    assign mem_stall  = stall_c & ~reset;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_trap = trap_c & ~reset;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: directed vector table, reset/trap sequences and random accesses
// on a LATENCY=2 instance (0) and a LATENCY=0 instance (1), checked cycle by cycle.
module tb_dmem_wait_responder;

    localparam int LAT_A = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        a_rd, a_wr, a_resp, a_stall;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_rd, b_wr, b_resp, b_stall;
    logic [31:0] b_addr, b_wdata, b_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        a_trap, b_trap;
`endif

    dmem_wait_responder #(.DEPTH(256), .LATENCY(LAT_A)) dut_a (
        .clock(clock), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
        .resp_valid(a_resp), .mem_stall(a_stall)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .misalign_trap(a_trap)
`endif
    );

    dmem_wait_responder #(.DEPTH(256), .LATENCY(0)) dut_b (
        .clock(clock), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr),
        .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
        .resp_valid(b_resp), .mem_stall(b_stall)
`ifdef DMEM_MISALIGN_TRAP_EN
        , .misalign_trap(b_trap)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference memory contents per instance; a word is only checked once written.
    logic [31:0] mdl   [2][256];
    bit          known [2][256];

    typedef struct {
        int          w;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          use_exp;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (w == 0) begin
            a_rd = rd; a_wr = wr; a_addr = a; a_wdata = wd;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = a; b_wdata = wd;
        end
    endtask

    task automatic sample(input int w, output logic st, output logic rv,
                          output logic [31:0] rd, output logic tp);
        tp = 1'b0;
        if (w == 0) begin
            st = a_stall; rv = a_resp; rd = a_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
            tp = a_trap;
`endif
        end else begin
            st = b_stall; rv = b_resp; rd = b_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
            tp = b_trap;
`endif
        end
    endtask

    task automatic idle_chk(input int w);
        logic st, rv, tp;
        logic [31:0] rd;
        @(negedge clock);
        drive(w, 1'b0, 1'b0, $urandom, $urandom);
        #1;
        sample(w, st, rv, rd, tp);
        chk("idle_stall", 32'(st), 32'd0);
        chk("idle_resp", 32'(rv), 32'd0);
        chk("idle_rdata", rd, 32'd0);
    endtask

    // One complete access: LAT stall cycles, then a response cycle; inputs are scrambled while busy.
    task automatic access(input int w, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit use_exp, input logic [31:0] exp);
        int lat;
        int ix;
        bit mis;
        bit check_data;
        logic [31:0] want;
        logic st, rv, tp;
        logic [31:0] rdv;
        lat = (w == 0) ? LAT_A : 0;
        ix  = int'(a[9:2]);
        mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (a[1:0] != 2'b00);
`endif
        if (mis) lat = 0;
        check_data = 1'b1;
        want = 32'h0;
        if (wr || mis) want = 32'h0;
        else if (use_exp) want = exp;
        else if (known[w][ix]) want = mdl[w][ix];
        else check_data = 1'b0;

        for (int k = 0; k <= lat; k++) begin
            @(negedge clock);
            if (k == 0) drive(w, rd, wr, a, wd);
            else drive(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            #1;
            sample(w, st, rv, rdv, tp);
            chk("stall", 32'(st), (k < lat) ? 32'd1 : 32'd0);
            chk("resp", 32'(rv), (k == lat) ? 32'd1 : 32'd0);
            if (k < lat) chk("rdata_busy", rdv, 32'h0);
            else if (check_data) chk("rdata", rdv, want);
`ifdef DMEM_MISALIGN_TRAP_EN
            chk("trap", 32'(tp), (mis && k == lat) ? 32'd1 : 32'd0);
`endif
        end
        if (wr && !mis) begin
            mdl[w][ix]   = wd;
            known[w][ix] = 1'b1;
        end
    endtask

    initial begin
        logic st, rv, tp;
        logic [31:0] rdv;
        logic [31:0] ra;

        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++) known[w][i] = 1'b0;

        // Directed accesses: {dut, rd, wr, addr, wdata, use_exp, exp}
        tbl.push_back('{0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF});
        tbl.push_back('{0, 1'b0, 1'b1, 32'h400, 32'hA5,       1'b0, 32'h0});
        tbl.push_back('{0, 1'b1, 1'b0, 32'h000, 32'h0,        1'b1, 32'hA5});
        tbl.push_back('{0, 1'b1, 1'b1, 32'h8,   32'h77,       1'b0, 32'h0});
        tbl.push_back('{0, 1'b1, 1'b0, 32'h8,   32'h0,        1'b1, 32'h77});
        tbl.push_back('{0, 1'b0, 1'b1, 32'h20,  32'h5,        1'b0, 32'h0});
        tbl.push_back('{1, 1'b0, 1'b1, 32'h40,  32'h1234,     1'b0, 32'h0});
        tbl.push_back('{1, 1'b1, 1'b0, 32'h40,  32'h0,        1'b1, 32'h1234});
        tbl.push_back('{1, 1'b0, 1'b1, 32'h7FC, 32'hCAFE,     1'b0, 32'h0});
        tbl.push_back('{1, 1'b1, 1'b0, 32'h3FC, 32'h0,        1'b1, 32'hCAFE});
        tbl.push_back('{1, 1'b1, 1'b1, 32'h8,   32'h77,       1'b0, 32'h0});
        tbl.push_back('{1, 1'b1, 1'b0, 32'h1008, 32'h0,       1'b1, 32'h77});

        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clock);
        #1;
        sample(0, st, rv, rdv, tp);
        chk("rst_a_stall", 32'(st), 32'd0);
        chk("rst_a_resp", 32'(rv), 32'd0);
        chk("rst_a_rdata", rdv, 32'd0);
        sample(1, st, rv, rdv, tp);
        chk("rst_b_resp", 32'(rv), 32'd0);
        chk("rst_b_rdata", rdv, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        idle_chk(0);
        idle_chk(1);

        foreach (tbl[i])
            access(tbl[i].w, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].use_exp, tbl[i].exp);
        idle_chk(0);

        // Reset in the middle of a store must drop it.
        @(negedge clock);
        drive(0, 1'b0, 1'b1, 32'h20, 32'h99);
        #1;
        sample(0, st, rv, rdv, tp);
        chk("rst_mid_req_stall", 32'(st), 32'd1);
        @(negedge clock);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        sample(0, st, rv, rdv, tp);
        chk("rst_mid_busy_stall", 32'(st), 32'd1);
        #1 reset = 1'b1;
        #1;
        sample(0, st, rv, rdv, tp);
        chk("rst_mid_stall", 32'(st), 32'd0);
        chk("rst_mid_resp", 32'(rv), 32'd0);
        chk("rst_mid_rdata", rdv, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h5);

`ifdef DMEM_MISALIGN_TRAP_EN
        access(0, 1'b0, 1'b1, 32'h13, 32'h1111, 1'b0, 32'h0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        access(1, 1'b1, 1'b0, 32'h42, 32'h0, 1'b0, 32'h0);
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h1234);
`endif

        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 150; n++) begin
                int op;
                op = int'($urandom_range(0, 2));
                ra = $urandom;
                ra[9:2] = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) idle_chk(w);
                case (op)
                    0: access(w, 1'b1, 1'b0, ra, 32'h0, 1'b0, 32'h0);
                    1: access(w, 1'b0, 1'b1, ra, $urandom, 1'b0, 32'h0);
                    default: access(w, 1'b1, 1'b1, ra, $urandom, 1'b0, 32'h0);
                endcase
            end
            idle_chk(w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
